// File: rtl/ram_arb_pkg.sv
// Shared definitions for the four-port RAM8 arbiter: FSM encoding and default sizing.
// Optional feature macro used by the arbiter: RAM_ARB_LOCK_EN.
package ram_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 16;
    localparam int AW_DEF    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request found searching upward
// from (last + 1) mod NREQ, returned both one-hot and as an index.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   index,
    output logic            any
);

    logic [IW-1:0] cand;

    always_comb begin
        pick  = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= unsigned'(NREQ); k++) begin
            cand = IW'((32'(last) + k) % unsigned'(NREQ));
            if (!any && req[cand]) begin
                any         = 1'b1;
                index       = cand;
                pick[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM8 between NREQ requesters, one access per grant.
// Define RAM_ARB_LOCK_EN to add the lock port for back-to-back locked accesses.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef RAM_ARB_LOCK_EN
    input  logic [NREQ-1:0]       lock,
`endif
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       we,
    input  logic [NREQ*AW-1:0]    addr,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rvalid,
    output logic [WIDTH-1:0]      rdata,
    output logic                  mem_load,
    output logic [AW-1:0]         mem_addr,
    output logic [WIDTH-1:0]      mem_in,
    input  logic [WIDTH-1:0]      mem_out
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e           state_q, state_d;
    logic [IW-1:0]    g_q, g_d;
    logic [IW-1:0]    last_q, last_d;
    logic [NREQ-1:0]  goh_q, goh_d;
    logic [NREQ-1:0]  rvalid_q, rvalid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic [NREQ-1:0]  pick;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             stay;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .pick  (pick),
        .index (pick_idx),
        .any   (pick_any)
    );

`ifdef RAM_ARB_LOCK_EN
    assign stay = lock[g_q] & req[g_q];
`else
    assign stay = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            g_q      <= '0;
            goh_q    <= '0;
            last_q   <= IW'(NREQ - 1);
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            goh_q    <= goh_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Read data is captured from the RAM during the grant cycle and presented one cycle later.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        goh_d    = goh_q;
        last_d   = last_q;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    g_d     = pick_idx;
                    goh_d   = pick;
                end
            end
            GRANT: begin
                if (!we[g_q]) begin
                    rvalid_d = goh_q;
                    rdata_d  = mem_out;
                end
                if (!stay) begin
                    state_d = IDLE;
                    last_d  = g_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt      = '0;
        mem_load = 1'b0;
        mem_addr = '0;
        mem_in   = '0;
        if (state_q == GRANT && !reset) begin
            gnt      = goh_q;
            mem_load = we[g_q];
            mem_addr = addr[g_q*AW +: AW];
            mem_in   = wdata[g_q*WIDTH +: WIDTH];
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, the number of requesters (fixed at 4 in this revision).
REQ-002 SHALL have parameter WIDTH, default 16, the data word width.
REQ-003 SHALL have parameter AW, default 3, the shared RAM8 address width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  NREQ  per-requester access request, held until gnt is seen.
REQ-007 SHALL have port we  input  NREQ  per-requester write enable (1 = write, 0 = read).
REQ-008 SHALL have port addr  input  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
REQ-009 SHALL have port wdata  input  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port gnt  output  NREQ  one-hot grant; marks the cycle in which the access executes.
REQ-011 SHALL have port rvalid  output  NREQ  one-hot read-data-valid strobe.
REQ-012 SHALL have port rdata  output  WIDTH  read data returned to the requester flagged in rvalid.
REQ-013 SHALL have port mem_load  output  1  RAM write enable.
REQ-014 SHALL have port mem_addr  output  AW  RAM address.
REQ-015 SHALL have port mem_in  output  WIDTH  RAM write data.
REQ-016 SHALL have port mem_out  input  WIDTH  RAM combinational read data.

Function
REQ-017 SHALL implement FSM states IDLE and GRANT.
REQ-018 In IDLE with any req bit set, SHALL select the requester by round-robin, searching from (last+1) mod NREQ, then register it and enter GRANT.
REQ-019 In GRANT, SHALL assert gnt[g] only; mem_addr, mem_in and mem_load=we[g] SHALL come combinationally from requester g's inputs.
REQ-020 SHALL update last to g on leaving GRANT and return to IDLE, so each grant lasts exactly one cycle and throughput is one access per two cycles.
REQ-021 On a read grant, SHALL assert rvalid[g] with rdata = the mem_out captured during the GRANT cycle, one cycle after GRANT; rvalid is a single-cycle pulse.
REQ-022 SHALL NOT assert rvalid for writes; rdata SHALL hold its last value when rvalid is 0.
REQ-023 SHALL drive mem_load=0 in IDLE and whenever reset=1.
REQ-024 SHALL ignore req deasserted before grant (no grant, no RAM access).
REQ-025 With only one requester active, SHALL grant it every second cycle.

Reset
REQ-026 On reset, SHALL set state=IDLE, gnt=0, rvalid=0, rdata=0, mem_addr=0, mem_in=0, mem_load=0, and last=NREQ-1 so requester 0 wins first.
REQ-027 Reset asserted during GRANT SHALL suppress that cycle's write and any pending rvalid.

Configuration
REQ-028 With macro RAM_ARB_LOCK_EN defined, SHALL add input port lock (NREQ bits); in GRANT, if lock[g] and req[g] are both 1, SHALL stay in GRANT for g, giving back-to-back accesses with addr/we/wdata sampled fresh each cycle.
REQ-029 Without RAM_ARB_LOCK_EN, SHALL have no lock port and SHALL behave exactly as REQ-017 to REQ-025.

Structure
REQ-030 SHALL take the state encodings (IDLE=0, GRANT=1) and the NREQ/WIDTH/AW defaults from shared package ram_arb_pkg.
REQ-031 SHALL place the combinational round-robin picker in sub-module rr_pick (inputs: req, last; outputs: one-hot pick, index, any).

Verification
REQ-032 SHALL test reset priority: after reset, req=4'b1111 at once -> gnt sequence 0001, 0010, 0100, 1000, on every second cycle.
REQ-033 SHALL test write then read: requester 2 writes 16'hBEEF to addr 5, then requester 1 reads addr 5 -> rvalid=4'b0010 and rdata=16'hBEEF one cycle after its grant.
REQ-034 SHALL test fairness: req=4'b1001 held -> grants alternate 0001, 1000, 0001, 1000.
REQ-035 SHALL test reset mid-grant: assert reset during requester 3's write grant to addr 1 -> mem_load=0 that cycle, RAM[1] unchanged, and all outputs 0 next cycle.
REQ-036 SHALL test lock with RAM_ARB_LOCK_EN: lock[0]=1, req=4'b0011 -> gnt=0001 for 3 consecutive cycles; after lock drops, the next grant is 0010.
REQ-037 SHALL test a lone requester: req=4'b0100 only -> gnt=0100 on alternate cycles, with no grant to any other requester.
